// File: rtl/battery_bank_ctrl.sv
// rtl/battery_bank_ctrl.sv - N-channel battery monitor with debounced empty/full flags
// and round-robin selection of the active discharge source.
module battery_flag_debounce #(
   parameter int DEBOUNCE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic flag
);
   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [CW-1:0] cnt;

   // The flag flips on the edge where the count would reach DEBOUNCE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         flag <= 1'b0;
      end else if (raw == flag) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
         flag <= ~flag;
         cnt  <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

module battery_bank_ctrl #(
   parameter int WIDTH     = 4,
   parameter int CHANNELS  = 2,
   parameter int EMPTY_LVL = 0,
   parameter int FULL_LVL  = 2**WIDTH - 1,
   parameter int DEBOUNCE  = 2,
   parameter int IDX_W     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] batt,
   output logic [CHANNELS-1:0]       is_empty,
   output logic                      full_state,
   output logic                      all_empty,
   output logic                      active_valid,
   output logic [IDX_W-1:0]          active_idx,
   output logic                      switch_pulse
);
   typedef enum logic [1:0] {SCAN, RUN, SWITCH, DEPLETED} state_t;

   state_t               state, state_n;
   logic [CHANNELS-1:0]  raw_empty, raw_full, full_flag;
   logic                 scan_found, rr_found;
   logic [IDX_W-1:0]     scan_idx, rr_idx;
   logic [IDX_W-1:0]     idx_n;
   logic                 valid_n, pulse_n;
   int                   cand;

   always_comb begin
      raw_empty = '0;
      raw_full  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         raw_empty[i] = (batt[i*WIDTH +: WIDTH] <= WIDTH'(EMPTY_LVL));
         raw_full[i]  = (batt[i*WIDTH +: WIDTH] >= WIDTH'(FULL_LVL));
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      battery_flag_debounce #(.DEBOUNCE(DEBOUNCE)) u_empty (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw_empty[g]),
         .flag (is_empty[g])
      );
      battery_flag_debounce #(.DEBOUNCE(DEBOUNCE)) u_full (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw_full[g]),
         .flag (full_flag[g])
      );
   end

   // Descending loops let the lowest index / nearest successor win.
   always_comb begin
      scan_found = 1'b0;
      scan_idx   = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (!is_empty[i]) begin
            scan_found = 1'b1;
            scan_idx   = IDX_W'(i);
         end
      end
      rr_found = 1'b0;
      rr_idx   = active_idx;
      cand     = 0;
      for (int k = CHANNELS - 1; k >= 1; k--) begin
         cand = (int'(active_idx) + k) % CHANNELS;
         if (!is_empty[cand]) begin
            rr_found = 1'b1;
            rr_idx   = IDX_W'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= SCAN;
         active_idx   <= '0;
         active_valid <= 1'b0;
         switch_pulse <= 1'b0;
         full_state   <= 1'b0;
         all_empty    <= 1'b0;
      end else begin
         state        <= state_n;
         active_idx   <= idx_n;
         active_valid <= valid_n;
         switch_pulse <= pulse_n;
         full_state   <= &full_flag;
         all_empty    <= &is_empty;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         SCAN:     state_n = scan_found ? RUN : DEPLETED;
         RUN:      if (is_empty[active_idx]) state_n = SWITCH;
         SWITCH:   state_n = rr_found ? RUN : DEPLETED;
         DEPLETED: if (!(&is_empty)) state_n = SCAN;
         default:  state_n = SCAN;
      endcase
   end

   always_comb begin
      idx_n   = active_idx;
      valid_n = active_valid;
      pulse_n = 1'b0;
      case (state)
         SCAN: begin
            valid_n = scan_found;
            if (scan_found) idx_n = scan_idx;
         end
         SWITCH: begin
            valid_n = rr_found;
            pulse_n = rr_found;
            if (rr_found) idx_n = rr_idx;
         end
         DEPLETED: valid_n = 1'b0;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_battery_bank_ctrl.sv
// tb/tb_battery_bank_ctrl.sv - scoreboard bench for battery_bank_ctrl (WIDTH=4, CHANNELS=2, DEBOUNCE=2).
module tb_battery_bank_ctrl;
   localparam int DEB = 2;
   localparam int S_SCAN = 0, S_RUN = 1, S_SW = 2, S_DEP = 3;

   typedef struct packed {
      logic [1:0] e;
      logic       fs;
      logic       ae;
      logic       v;
      logic       idx;
      logic       p;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] batt;
   logic [1:0] is_empty;
   logic       full_state, all_empty, active_valid, switch_pulse;
   logic [0:0] active_idx;

   exp_t sb[$];
   int   n_checks = 0, n_pass = 0;
   int   pulse_total = 0, mark;
   logic prev_pulse = 1'b0;

   logic [1:0] m_empty, m_full;
   int         m_ecnt[2], m_fcnt[2];
   logic       m_fs, m_ae, m_valid, m_pulse;
   logic [0:0] m_idx;
   int         m_state;

   battery_bank_ctrl #(.WIDTH(4), .CHANNELS(2), .EMPTY_LVL(0), .FULL_LVL(15), .DEBOUNCE(DEB)) dut (
      .clk          (clk),
      .rst          (rst),
      .batt         (batt),
      .is_empty     (is_empty),
      .full_state   (full_state),
      .all_empty    (all_empty),
      .active_valid (active_valid),
      .active_idx   (active_idx),
      .switch_pulse (switch_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_edge(input logic r, input logic [7:0] b);
      logic [1:0] raw_e, raw_f;
      int         ns;
      logic       nv, np;
      logic [0:0] ni;
      if (r) begin
         m_empty = 0; m_full = 0; m_ecnt = '{0, 0}; m_fcnt = '{0, 0};
         m_fs = 0; m_ae = 0; m_valid = 0; m_pulse = 0; m_idx = 0; m_state = S_SCAN;
         return;
      end
      for (int i = 0; i < 2; i++) begin
         raw_e[i] = (b[i*4 +: 4] == 4'd0);
         raw_f[i] = (b[i*4 +: 4] == 4'd15);
      end
      ns = m_state; nv = m_valid; np = 0; ni = m_idx;
      case (m_state)
         S_SCAN:
            if (!m_empty[0])      begin ni = 0; nv = 1; ns = S_RUN; end
            else if (!m_empty[1]) begin ni = 1; nv = 1; ns = S_RUN; end
            else                  begin nv = 0; ns = S_DEP; end
         S_RUN: if (m_empty[m_idx]) ns = S_SW;
         S_SW:
            if (!m_empty[~m_idx]) begin ni = ~m_idx; np = 1; ns = S_RUN; end
            else                  begin nv = 0; ns = S_DEP; end
         default: begin nv = 0; if (m_empty != 2'b11) ns = S_SCAN; end
      endcase
      m_state = ns; m_valid = nv; m_pulse = np; m_idx = ni;
      m_fs = &m_full;
      m_ae = &m_empty;
      for (int i = 0; i < 2; i++) begin
         if (raw_e[i] == m_empty[i]) m_ecnt[i] = 0;
         else if (m_ecnt[i] + 1 == DEB) begin m_empty[i] = ~m_empty[i]; m_ecnt[i] = 0; end
         else m_ecnt[i]++;
         if (raw_f[i] == m_full[i]) m_fcnt[i] = 0;
         else if (m_fcnt[i] + 1 == DEB) begin m_full[i] = ~m_full[i]; m_fcnt[i] = 0; end
         else m_fcnt[i]++;
      end
   endtask

   task automatic cycle(input logic r, input logic [3:0] b1, input logic [3:0] b0);
      exp_t e;
      rst  = r;
      batt = {b1, b0};
      model_edge(r, {b1, b0});
      e.e = m_empty; e.fs = m_fs; e.ae = m_ae; e.v = m_valid; e.idx = m_idx; e.p = m_pulse;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_underflow", 0, 1);
      end else begin
         e = sb.pop_front();
         check("is_empty", is_empty, e.e);
         check("full_state", full_state, e.fs);
         check("all_empty", all_empty, e.ae);
         check("active_valid", active_valid, e.v);
         check("active_idx", active_idx, e.idx);
         check("switch_pulse", switch_pulse, e.p);
      end
      check("no_double_pulse", prev_pulse & switch_pulse, 0);
      prev_pulse = switch_pulse;
      pulse_total += int'(switch_pulse);
   endtask

   initial begin
      rst = 1'b1;
      batt = 8'h77;
      cycle(1, 7, 7);
      cycle(1, 7, 7);
      check("rst_valid", active_valid, 0);
      check("rst_empty", is_empty, 0);

      cycle(0, 7, 7);
      check("rel_valid", active_valid, 1);
      check("rel_idx", active_idx, 0);
      cycle(0, 7, 7);

      // Single-cycle dip on ch0 must be filtered out.
      mark = pulse_total;
      cycle(0, 7, 0);
      for (int i = 0; i < 4; i++) cycle(0, 7, 3);
      check("glitch_empty", is_empty, 0);
      check("glitch_idx", active_idx, 0);
      check("glitch_pulses", pulse_total - mark, 0);

      // ch0 depletes: flag on 2nd edge, switch two edges later.
      mark = pulse_total;
      cycle(0, 7, 0);
      cycle(0, 7, 0);
      check("ch0_flag", is_empty[0], 1);
      cycle(0, 7, 0);
      check("pre_switch_idx", active_idx, 0);
      cycle(0, 7, 0);
      check("sw_idx", active_idx, 1);
      check("sw_pulse", switch_pulse, 1);
      for (int i = 0; i < 3; i++) cycle(0, 7, 0);
      check("hold_pulses", pulse_total - mark, 1);

      // Recovering ch0 must not preempt ch1.
      for (int i = 0; i < 4; i++) cycle(0, 7, 7);
      check("no_preempt", active_idx, 1);

      // Both depleted, then ch1 recovers.
      for (int i = 0; i < 6; i++) cycle(0, 0, 0);
      check("dep_all_empty", all_empty, 1);
      check("dep_valid", active_valid, 0);
      mark = pulse_total;
      for (int i = 0; i < 5; i++) cycle(0, 3, 0);
      check("rec_valid", active_valid, 1);
      check("rec_idx", active_idx, 1);
      check("rec_pulses", pulse_total - mark, 0);

      // Full detection and release.
      for (int i = 0; i < 4; i++) cycle(0, 15, 15);
      check("full_set", full_state, 1);
      cycle(0, 14, 15);
      cycle(0, 14, 15);
      check("full_lag", full_state, 1);
      cycle(0, 14, 15);
      check("full_clear", full_state, 0);
      cycle(0, 14, 15);

      // Reset while the FSM is in SWITCH.
      for (int i = 0; i < 10 && m_state != S_SW; i++) cycle(0, 0, 7);
      cycle(1, 0, 7);
      check("rst_sw_pulse", switch_pulse, 0);
      check("rst_sw_valid", active_valid, 0);
      check("rst_sw_idx", active_idx, 0);
      check("rst_sw_empty", is_empty, 0);
      for (int i = 0; i < 3; i++) cycle(0, 7, 7);
      check("post_rst_valid", active_valid, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/battery_bank_ctrl.md
# battery_bank_ctrl

Sequential, N-channel successor to the two-battery bench. It monitors CHANNELS battery level words and debounces per-channel empty and full flags. It also selects which battery is the active discharge source and rotates to the next usable battery round-robin when the active one depletes. It sits between the battery level sensors and the power-path switch logic.

## Interface

- WIDTH, 4, bits per battery level word (unsigned, 0 .. 2^WIDTH-1)
- CHANNELS, 2, number of batteries (>= 2)
- EMPTY_LVL, 0, level at or below which a channel is raw-empty
- FULL_LVL, 2^WIDTH-1, level at or above which a channel is raw-full
- DEBOUNCE, 2, consecutive cycles a raw condition must persist before its flag changes (>= 1)
- IDX_W, $clog2(CHANNELS), derived width of active_idx

Reset is synchronous and active-high, with a single clock.

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- batt  in  CHANNELS*WIDTH  packed levels; channel i at [i*WIDTH +: WIDTH]
- is_empty  out  CHANNELS  debounced per-channel empty flags
- full_state  out  1  registered: all debounced full flags set
- all_empty  out  1  registered: all debounced empty flags set
- active_valid  out  1  an active channel is selected
- active_idx  out  IDX_W  index of active discharge channel
- switch_pulse  out  1  one-cycle strobe when active_idx changes due to depletion

## Operation

- Raw conditions per channel:
  - raw_empty = (level <= EMPTY_LVL)
  - raw_full = (level >= FULL_LVL)
  - Both are unsigned compares at WIDTH bits.
- Debouncer per channel per flag:
  - A counter increments on each edge where the raw condition differs from the flag.
  - The counter clears to 0 on any edge where the raw condition equals the flag.
  - The flag toggles, and the counter clears, on the edge where the counter would reach DEBOUNCE.
  - Counter width is $clog2(DEBOUNCE+1).
- full_state and all_empty are registered ANDs of the debounced flags. They lag those flags by one cycle.
- FSM states:
  - SCAN:
    - Selects the lowest index i with is_empty[i]=0, sets active_idx=i and active_valid=1, and goes to RUN.
    - If no such channel exists, goes to DEPLETED.
    - switch_pulse stays 0 in SCAN.
  - RUN:
    - Holds active_idx.
    - When is_empty[active_idx]=1, goes to SWITCH.
  - SWITCH:
    - Searches active_idx+1, active_idx+2, ..., wrapping modulo CHANNELS and excluding active_idx itself, for the first channel with is_empty=0.
    - If found: active_idx is updated to it, switch_pulse=1 for exactly that next cycle, and the FSM goes to RUN.
    - If none is found: active_valid=0, switch_pulse=0, and the FSM goes to DEPLETED.
  - DEPLETED:
    - active_valid=0 and active_idx holds its last value.
    - When any is_empty bit clears, goes to SCAN.
- A channel recovering while another is active does not preempt the active channel.

## Timing

- Reset values:
  - is_empty=0, full_state=0, all_empty=0
  - active_valid=0, active_idx=0, switch_pulse=0
  - All debounce counters 0, debounced full flags 0, state=SCAN
- After rst deasserts, the first edge executes SCAN. active_valid=1 and active_idx=0 are visible after that edge, because the flags are 0 out of reset.
- Flag latency: a raw change stable from edge t sets or clears the flag at edge t+DEBOUNCE-1. With DEBOUNCE=1 the flag is the raw condition registered.
- Depletion-to-switch latency: the flag rises at edge e, the FSM enters SWITCH at e+1, and active_idx and switch_pulse update at e+2.
- switch_pulse is never high for two consecutive cycles.
- Simultaneous events:
  - The active channel and the round-robin candidate empty on the same edge: SWITCH skips the candidate, because it sees the updated flags.
  - Every other channel is empty: the FSM goes to DEPLETED with no pulse.
- rst asserted in any state, including mid-debounce or SWITCH, restores all reset values on that edge.
- rst has priority over all other activity.

## Test plan

All scenarios use WIDTH=4, CHANNELS=2, DEBOUNCE=2.

- Reset with batt={7,7}, then release:
  - After the first edge: active_valid=1, active_idx=0, is_empty=00, full_state=0.
- ch0 set to 0 and held:
  - is_empty[0]=1 on the 2nd edge.
  - Two edges later: active_idx=1 and switch_pulse=1 for one cycle.
- ch0 set to 0 for one cycle, then to 3:
  - No flag change, switch_pulse stays 0, active_idx stays 0.
- Both channels set to 0:
  - all_empty=1 and active_valid=0 (DEPLETED).
  - Then ch1 set to 3: is_empty[1] clears after 2 edges, and SCAN gives active_idx=1, active_valid=1, switch_pulse=0.
- Both channels set to 15 for 2+ cycles:
  - full_state=1.
  - Then {14,15}: full_state=0 after 2 edges plus 1 register edge.
- rst pulsed for one cycle while in SWITCH:
  - All outputs return to reset values, and no switch_pulse is emitted.
